// File: rtl/seq_piso_serializer.sv
// seq_piso_serializer
//   Parallel-in / serial-out stage feeding the Moore sequence detector.
//   Words arrive over a valid/ready handshake and leave one bit per clock
//   on ser_out. A word can be reloaded on the edge that ends the previous
//   word's last bit, so back-to-back words form an unbroken bit stream.
//   While stall is high the stream freezes without losing any bits.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//   IDLE_BIT   level driven on ser_out when no word is being shifted
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active low
//   load_valid  load_data holds a word to serialize
//   load_data   word to serialize, sampled only on an accepting edge
//   load_ready  a word can be accepted this cycle
//   stall       freezes shifting while high
//   ser_out     serial bit stream
//   ser_valid   ser_out carries a data bit this cycle
//   busy        a word is in flight
//   done        high while the last bit of a word is presented
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word in flight, ser_out = IDLE_BIT
// SHIFT | presenting bit cnt of the current word (send order)
module seq_piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             stall,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             at_last;
    logic             accept;

    assign at_last    = (state == SHIFT) && (cnt == LAST);
    // The reload slot is the edge that retires the last bit, which is what
    // keeps consecutive words gapless.
    assign load_ready = rst && !stall && ((state == IDLE) || at_last);
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else if (accept) begin
            shreg <= load_data;
            cnt   <= '0;
            state <= SHIFT;
        end else if ((state == SHIFT) && !stall) begin
            if (cnt == LAST) begin
                state <= IDLE;
            end else begin
                if (MSB_FIRST)
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                else
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Outputs come from registered state only; stall merely masks the
    // qualifiers, so ser_out keeps showing the held bit during a stall.
    assign busy      = (state == SHIFT);
    assign ser_valid = busy && !stall;
    assign done      = ser_valid && (cnt == LAST);
    assign ser_out   = !busy ? IDLE_BIT :
                       (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

endmodule

// File: tb/tb_seq_piso_serializer.sv
module tb_seq_piso_serializer;

    typedef struct packed {
        logic b;
        logic last;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data8 = '0;
    logic [3:0] load_data4 = '0;
    logic       stall = 1'b0;

    logic rdy[2];
    logic so[2];
    logic sv[2];
    logic bz[2];
    logic dn[2];

    // dut0: WIDTH=8, MSB first, idle 0.  dut1: WIDTH=4, LSB first, idle 1.
    seq_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut8 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data8),
        .load_ready(rdy[0]), .stall(stall), .ser_out(so[0]), .ser_valid(sv[0]),
        .busy(bz[0]), .done(dn[0])
    );

    seq_piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data4),
        .load_ready(rdy[1]), .stall(stall), .ser_out(so[1]), .ser_valid(sv[1]),
        .busy(bz[1]), .done(dn[1])
    );

    always #5 clk = ~clk;

    // Reference model: bits still owed by each DUT, in send order.
    ent_t q0[$];
    ent_t q1[$];
    int   rem[2]  = '{0, 0};
    int   wd[2]   = '{8, 4};
    bit   msb[2]  = '{1'b1, 1'b0};
    bit   idleb[2] = '{1'b0, 1'b1};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %b expected %b", name, k, $time, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ent_t qfront(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int k, input ent_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic qclear(input int k);
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    function automatic ent_t qpop(input int k);
        return (k == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    // One clock: drive at negedge, check handshake/state outputs, then
    // advance the model at the rising edge.
    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit s);
        bit   acc;
        ent_t e;
        int   idx;
        @(negedge clk);
        rst        = r;
        load_valid = v;
        load_data8 = d;
        load_data4 = d[3:0];
        stall      = s;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("load_ready", k, rdy[k], r && !s && (rem[k] <= 1));
            chk("busy", k, bz[k], rem[k] > 0);
            chk("ser_valid", k, sv[k], (rem[k] > 0) && !s);
            if (rem[k] == 0)
                chk("ser_out_idle", k, so[k], idleb[k]);
            else if (qsize(k) > 0)
                chk("ser_out_hold", k, so[k], qfront(k).b);
            if (!((rem[k] > 0) && !s))
                chk("done_quiet", k, dn[k], 1'b0);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                rem[k] = 0;
                qclear(k);
            end else begin
                acc = v && !s && (rem[k] <= 1);
                if (rem[k] > 0 && !s) rem[k]--;
                if (acc) begin
                    for (int i = 0; i < wd[k]; i++) begin
                        idx    = msb[k] ? (wd[k] - 1 - i) : i;
                        e.b    = d[idx];
                        e.last = (i == wd[k] - 1);
                        qpush(k, e);
                    end
                    rem[k] = wd[k];
                end
            end
        end
    endtask

    // Monitor: every presented data bit consumes one scoreboard entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < 2; k++) begin
                if (sv[k] === 1'b1) begin
                    chk("sb_nonempty", k, qsize(k) > 0, 1'b1);
                    if (qsize(k) > 0) begin
                        e = qpop(k);
                        chk("ser_bit", k, so[k], e.b);
                        chk("done_last", k, dn[k], e.last);
                    end
                end
            end
        end
    end

    initial begin
        // reset, then idle
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'hAA, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 1);
        // single word
        step(1, 1, 8'hDB, 0);
        repeat (9) step(1, 0, 8'h00, 0);
        // gapless pair: second word held until the last-bit edge
        step(1, 1, 8'hB6, 0);
        repeat (8) step(1, 1, 8'h5A, 0);
        repeat (9) step(1, 0, 8'h00, 0);
        // stall mid-word
        step(1, 1, 8'hF0, 0);
        repeat (3) step(1, 0, 8'h00, 0);
        repeat (3) step(1, 1, 8'h0F, 1);
        repeat (7) step(1, 0, 8'h00, 0);
        // reset mid-word, then a fresh word
        step(1, 1, 8'hFF, 0);
        repeat (4) step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(1, 1, 8'h81, 0);
        repeat (9) step(1, 0, 8'h00, 0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) >= 2),
                 ($urandom_range(0, 99) < 60),
                 8'($urandom),
                 ($urandom_range(0, 99) < 20));
        end
        repeat (12) step(1, 0, 8'h00, 0);
        for (int k = 0; k < 2; k++)
            chk("drained", k, qsize(k) == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_piso_serializer.md
Name: seq_piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the Moore sequence detector.
- Accepts WIDTH-bit words through a valid/ready handshake and emits them one bit per clock on ser_out, which drives the detector's serial input.
- Supports gapless back-to-back words, so the detector sees an unbroken bit stream across word boundaries.
- A stall input freezes the stream without losing bits.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on ser_out whenever no word is being shifted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- load_valid  input  1  load_data holds a word to be serialized.
- load_data  input  WIDTH  word to serialize; sampled only on an accepting edge.
- load_ready  output  1  block can accept a word this cycle.
- stall  input  1  freezes shifting while high.
- ser_out  output  1  serial bit stream to the detector.
- ser_valid  output  1  ser_out carries a data bit this cycle.
- busy  output  1  a word is in flight (state SHIFT).
- done  output  1  single-cycle pulse while the last bit of a word is presented.

Behaviour:
- Reset: on any rising edge with rst=0, the block takes the reset values and discards any in-flight word. This applies mid-word as well.
  - state=IDLE, bit counter=0, shift register=0.
  - ser_out=IDLE_BIT, ser_valid=0, busy=0, done=0.
  - load_ready is forced to 0 while rst=0.
- States: IDLE and SHIFT.
- Bit counter cnt: 0..WIDTH-1, width ceil(log2(WIDTH)).
- load_ready (combinational) = rst & ~stall & (state==IDLE | (state==SHIFT & cnt==WIDTH-1)).
- Accept = load_valid & load_ready at a rising edge. On accept:
  - shift register <= load_data, cnt <= 0, state <= SHIFT.
- Latency: bit 0 of the word (first in send order) appears on ser_out in the cycle after the accepting edge.
  - A word occupies exactly WIDTH non-stalled cycles.
- In SHIFT with stall=0, at each edge:
  - If cnt==WIDTH-1 and accept: reload as above (gapless; ser_valid stays 1).
  - If cnt==WIDTH-1 and no accept: state <= IDLE.
  - Otherwise: shift by one toward the output end, cnt <= cnt+1.
- In SHIFT with stall=1: shift register, cnt and state hold; ser_valid=0; ser_out holds the current bit value.
- Stall in IDLE has no effect other than forcing load_ready=0.
- Outputs are decoded from registered state only:
  - ser_out = shift register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) in SHIFT; IDLE_BIT in IDLE.
  - ser_valid = (state==SHIFT) & ~stall.
  - busy = (state==SHIFT).
  - done = ser_valid & cnt==WIDTH-1. It pulses once per word, is absent during a stall, and is asserted when the stall releases.
- load_data is ignored in any cycle without an accept; a valid held high while ready=0 is not lost.
- No combinational path from load_data to ser_out.

Test Plan:
- Reset, then idle: hold rst=0 for 2 cycles, release with load_valid=0 -> ser_out=IDLE_BIT(0), ser_valid=0, busy=0, done=0, load_ready=1 from the first cycle after release.
- Single word, WIDTH=8, MSB_FIRST=1: load 8'b1101_1011 -> cycles 1..8 after accept show ser_out 1,1,0,1,1,0,1,1 with ser_valid=1; done=1 in cycle 8 only; cycle 9 back to IDLE with ser_out=0.
- Gapless pair: load 8'hB6, hold load_valid with 8'h5A -> second word accepted at the last-bit edge of the first; 16 consecutive valid bits 10110110 01011010; done pulses in cycles 8 and 16; ser_valid never drops.
- Stall mid-word: load 8'hF0, assert stall for 3 cycles starting at bit 3 -> ser_valid=0 and ser_out held for 3 cycles; remaining bits resume unchanged; the 8 valid bits are still 11110000; done is delayed by 3 cycles.
- Reset mid-word: load 8'hFF, pull rst low after bit 4 -> next cycle ser_out=0, ser_valid=0, busy=0; after release, a fresh 8'h81 serializes as 1,0,0,0,0,0,0,1 with no residual bits.
- LSB-first variant (MSB_FIRST=0, WIDTH=4): load 4'b0011 -> ser_out 1,1,0,0; load_valid asserted while busy and not at the last bit -> load_ready=0 and no accept until the last bit.
